// File: rtl/modbus_pkg.sv
// ============================================================================
// modbus_pkg : shared Modbus RTU constants, state encoding and CRC-16 helper
// Rev 1.0
// ============================================================================
`default_nettype none

package modbus_pkg;

  localparam logic [7:0] FC_READ_HOLDING  = 8'h03;
  localparam logic [7:0] FC_READ_INPUT    = 8'h04;
  localparam logic [7:0] FC_WRITE_SINGLE  = 8'h06;

  localparam logic [7:0] EXC_ILLEGAL_FUNCTION = 8'h01;
  localparam logic [7:0] EXC_ILLEGAL_ADDRESS  = 8'h02;
  localparam logic [7:0] EXC_ILLEGAL_VALUE    = 8'h03;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  localparam logic [7:0] EXC_FLAG = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_READ   = 3'd3,
    ST_SEND   = 3'd4,
    ST_ACK    = 3'd5,
    ST_WAITTX = 3'd6,
    ST_DONE   = 3'd7
  } tx_state_t;

  typedef enum logic [1:0] {
    FRAME_EXC   = 2'd0,
    FRAME_READ  = 2'd1,
    FRAME_WRITE = 2'd2,
    FRAME_DROP  = 2'd3
  } frame_kind_t;

  // Reflected CRC-16/MODBUS, one byte processed LSB first.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                               input logic [7:0]  data_byte);
    logic [15:0] r;
    r = crc_in ^ {8'h00, data_byte};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/modbus_tx_frame_if.sv
// ============================================================================
// modbus_tx_frame_if : byte start/busy handshake between framer and UART TX
// Rev 1.0
// ============================================================================
`default_nettype none

interface modbus_tx_frame_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_byte, output tx_start, input tx_busy);
  modport slave  (input tx_byte, input tx_start, output tx_busy);
endinterface

`default_nettype wire

// File: rtl/modbus_crc16_byte.sv
// ============================================================================
// modbus_crc16_byte : registered CRC-16/MODBUS accumulator, one byte per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  in_byte,
  output logic [15:0] crc
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_update(crc, in_byte);
    end
  end

endmodule

`default_nettype wire

// File: rtl/modbus_tx_frame.sv
// ============================================================================
// modbus_tx_frame : Modbus RTU reply framer (exception / read / write echo)
// Optional macro MODBUS_TX_GAP_EN adds a pre-frame silence state.  Rev 1.0
// ============================================================================
`default_nettype none

module modbus_tx_frame
  import modbus_pkg::*;
#(
  parameter int MAX_REGS = 5
`ifdef MODBUS_TX_GAP_EN
  , parameter logic [15:0] GAP_CYCLES = 16'd1000
`endif
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [7:0]               dev_addr,
  input  logic                     exception_done,
  input  logic [7:0]               exception,
  input  logic [7:0]               func_code,
  input  logic [15:0]              addr,
  input  logic [15:0]              data,
  output logic [15:0]              reg_rd_addr,
  input  logic [15:0]              reg_rd_data,
  modbus_tx_frame_if.master        uart,
  output logic                     busy,
  output logic                     tx_frame_done
);

  localparam logic [7:0] MAX_N = 8'(MAX_REGS);

  tx_state_t   state, state_d;
  frame_kind_t kind_q, kind_in;

  logic [7:0]  dev_q, func_q, exc_q;
  logic [15:0] addr_q, data_q, reg_word;
  logic [7:0]  tx_byte_q, sel_byte;
  logic [3:0]  idx, frame_len;
  logic [7:0]  n_regs;
  logic        accept, tx_start;
  logic        is_crc_lo, is_crc_hi, reg_hi, reg_lo;
  logic [15:0] crc;

  always_comb begin
    kind_in = FRAME_DROP;
    if (exception != 8'h00)
      kind_in = FRAME_EXC;
    else if (func_code == FC_READ_HOLDING || func_code == FC_READ_INPUT)
      kind_in = FRAME_READ;
    else if (func_code == FC_WRITE_SINGLE)
      kind_in = FRAME_WRITE;
  end

  assign accept = (state == ST_IDLE) && exception_done && (kind_in != FRAME_DROP);

  assign n_regs = (data_q[7:0] > MAX_N) ? MAX_N : data_q[7:0];

  always_comb begin
    frame_len = 4'd5;
    case (kind_q)
      FRAME_READ:  frame_len = 4'(5 + 2 * int'(n_regs));
      FRAME_WRITE: frame_len = 4'd8;
      default:     frame_len = 4'd5;
    endcase
  end

  assign is_crc_lo = (idx == frame_len - 4'd2);
  assign is_crc_hi = (idx == frame_len - 4'd1);
  // Register payload sits between the byte count (idx 2) and the CRC.
  assign reg_hi = (kind_q == FRAME_READ) && (idx >= 4'd3) && !is_crc_lo && !is_crc_hi && idx[0];
  assign reg_lo = (kind_q == FRAME_READ) && (idx >= 4'd4) && !is_crc_lo && !is_crc_hi && !idx[0];

  always_comb begin
    sel_byte = 8'h00;
    if (idx == 4'd0) begin
      sel_byte = dev_q;
    end else if (is_crc_lo) begin
      sel_byte = crc[7:0];
    end else if (is_crc_hi) begin
      sel_byte = crc[15:8];
    end else begin
      case (kind_q)
        FRAME_EXC:   sel_byte = (idx == 4'd1) ? (func_q | EXC_FLAG) : exc_q;
        FRAME_WRITE: begin
          case (idx)
            4'd1:    sel_byte = FC_WRITE_SINGLE;
            4'd2:    sel_byte = addr_q[15:8];
            4'd3:    sel_byte = addr_q[7:0];
            4'd4:    sel_byte = data_q[15:8];
            default: sel_byte = data_q[7:0];
          endcase
        end
        FRAME_READ: begin
          if (idx == 4'd1)      sel_byte = func_q;
          else if (idx == 4'd2) sel_byte = 8'(2 * int'(n_regs));
          else                  sel_byte = reg_lo ? reg_word[7:0] : reg_word[15:8];
        end
        default: sel_byte = 8'h00;
      endcase
    end
  end

`ifdef MODBUS_TX_GAP_EN
  logic [15:0] gap_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)             gap_cnt <= 16'd0;
    else if (state == ST_GAP)  gap_cnt <= gap_cnt + 16'd1;
    else                       gap_cnt <= 16'd0;
  end
`endif

  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef MODBUS_TX_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef MODBUS_TX_GAP_EN
      ST_GAP:    if (gap_cnt >= GAP_CYCLES - 16'd1) state_d = ST_LOAD;
`endif
      ST_LOAD:   state_d = reg_hi ? ST_READ : ST_SEND;
      ST_READ:   state_d = ST_SEND;
      ST_SEND: begin
        if (!uart.tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:    state_d = ST_WAITTX;
      ST_WAITTX: if (!uart.tx_busy) state_d = is_crc_hi ? ST_DONE : ST_LOAD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      kind_q      <= FRAME_EXC;
      dev_q       <= 8'h00;
      func_q      <= 8'h00;
      exc_q       <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      reg_word    <= 16'h0000;
      tx_byte_q   <= 8'h00;
      idx         <= 4'd0;
      reg_rd_addr <= 16'h0000;
    end else begin
      state <= state_d;
      if (accept) begin
        kind_q      <= kind_in;
        dev_q       <= dev_addr;
        func_q      <= func_code;
        exc_q       <= exception;
        addr_q      <= addr;
        data_q      <= data;
        idx         <= 4'd0;
        reg_rd_addr <= addr;
      end
      if (state == ST_LOAD) tx_byte_q <= sel_byte;
      if (state == ST_READ) begin
        reg_word  <= reg_rd_data;
        tx_byte_q <= reg_rd_data[15:8];
      end
      if (state == ST_WAITTX && !uart.tx_busy && !is_crc_hi) begin
        idx <= idx + 4'd1;
        if (reg_lo) reg_rd_addr <= reg_rd_addr + 16'd1;
      end
    end
  end

  // CRC bytes themselves must not be folded back into the running CRC.
  modbus_crc16_byte u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear    (accept),
    .enable   (tx_start && !is_crc_lo && !is_crc_hi),
    .in_byte  (tx_byte_q),
    .crc      (crc)
  );

  assign uart.tx_byte  = tx_byte_q;
  assign uart.tx_start = tx_start;
  assign busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign tx_frame_done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_modbus_tx_frame.sv
// ============================================================================
// tb_modbus_tx_frame : scoreboard bench for the Modbus reply framer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_modbus_tx_frame;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [7:0]  dev_addr = 8'h00;
  logic        exception_done = 1'b0;
  logic [7:0]  exception = 8'h00;
  logic [7:0]  func_code = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data = 16'h0000;
  logic        busy, tx_frame_done;
  logic        uart_busy = 1'b0;

  modbus_tx_frame_if ifc ();
  assign ifc.tx_busy = uart_busy;

  modbus_tx_frame dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .dev_addr       (dev_addr),
    .exception_done (exception_done),
    .exception      (exception),
    .func_code      (func_code),
    .addr           (addr),
    .data           (data),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_data    (reg_rd_data),
    .uart           (ifc),
    .busy           (busy),
    .tx_frame_done  (tx_frame_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int frame_bytes = 0;
  int exp_frames = 0;
  int busy_len = 2;
  bit lat_armed = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [15:0] reg_val(input logic [15:0] a);
    return 16'(16'h1111 * (a + 16'd1));
  endfunction

  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] f[$], input bit add_crc);
    logic [15:0] c;
    logic [7:0]  q[$];
    q = f;
    if (add_crc) begin
      c = crc_model(f);
      q.push_back(c[7:0]);
      q.push_back(c[15:8]);
    end
    foreach (q[i]) exp_q.push_back(q[i]);
    exp_frames++;
  endtask

  task automatic issue(input logic [7:0] dv, input logic [7:0] fc, input logic [7:0] ex,
                       input logic [15:0] a, input logic [15:0] d);
    @(negedge clk_in);
    dev_addr = dv; func_code = fc; exception = ex; addr = a; data = d;
    exception_done = 1'b1;
    issue_cyc = cyc;
    frame_bytes = 0;
    @(negedge clk_in);
    exception_done = 1'b0;
  endtask

  task automatic check_busy_rose(input string name);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: got %0b required 1", name, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (ifc.tx_start !== 1'b0 || busy !== 1'b0 || tx_frame_done !== 1'b0 ||
        ifc.tx_byte !== 8'h00 || reg_rd_addr !== 16'h0000) begin
      bad++;
      $display("FAIL %s: start=%0b busy=%0b done=%0b byte=%02h rd_addr=%04h required all 0",
               name, ifc.tx_start, busy, tx_frame_done, ifc.tx_byte, reg_rd_addr);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (4) @(negedge clk_in);
    while ((busy || exp_frames != 0 || uart_busy) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (busy || exp_frames != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_complete: busy=%0b frames_left=%0d bytes_left=%0d required 0/0/0",
               name, busy, exp_frames, exp_q.size());
    end
  endtask

  // UART model: busy one cycle after the start pulse, held for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk_in);
      if (ifc.tx_start) begin
        @(posedge clk_in);
        #1 uart_busy = 1'b1;
        repeat (busy_len) @(posedge clk_in);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Register file model with one cycle of read latency.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk_in);
      a = reg_rd_addr;
      @(posedge clk_in);
      #1 reg_rd_data = reg_val(a);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_start;
    logic [7:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk_in);
      if (ifc.tx_start) begin
        total++;
        if (ifc.tx_busy || prev_start) begin
          bad++;
          $display("FAIL start_protocol: tx_busy=%0b prev_start=%0b required 0/0",
                   ifc.tx_busy, prev_start);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got %02h required no byte", ifc.tx_byte);
        end else begin
          e = exp_q.pop_front();
          if (ifc.tx_byte !== e) begin
            bad++;
            $display("FAIL tx_byte[%0d]: got %02h required %02h", frame_bytes, ifc.tx_byte, e);
          end
        end
        if (lat_armed) begin
          lat_armed = 0;
          total++;
          if (cyc - issue_cyc != 2) begin
            bad++;
            $display("FAIL first_start_latency: got %0d required 2", cyc - issue_cyc);
          end
        end
        frame_bytes++;
      end
      if (tx_frame_done) begin
        total++;
        if (exp_frames == 0 || exp_q.size() != 0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL frame_done: frames_pending=%0d bytes_left=%0d busy=%0b required >0/0/0",
                   exp_frames, exp_q.size(), busy);
        end else begin
          exp_frames--;
        end
      end
      prev_start = ifc.tx_start;
    end
  end

  initial begin
    logic [7:0] f[$];
    int n;

    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_state");
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Exception reply, hand-computed CRC.
    f = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    push_frame(f, 0);
    lat_armed = 1;
    issue(8'h01, 8'h03, 8'h02, 16'h0000, 16'h0000);
    check_busy_rose("exception");
    wait_idle("exception");

    // Write echo.
    f = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    push_frame(f, 0);
    issue(8'h01, 8'h06, 8'h00, 16'h0001, 16'h0003);
    check_busy_rose("write");
    wait_idle("write");

    // Read three input registers.
    f = '{8'h01, 8'h04, 8'h06, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    push_frame(f, 1);
    issue(8'h01, 8'h04, 8'h00, 16'h0000, 16'h0003);
    wait_idle("read3");

    // Read with zero quantity.
    f = '{8'h01, 8'h03, 8'h00};
    push_frame(f, 1);
    issue(8'h01, 8'h03, 8'h00, 16'h0040, 16'h0000);
    wait_idle("read0");

    // Quantity 9 clamps to five registers starting at 8.
    f = '{8'h01, 8'h03, 8'h0A, 8'h99, 8'h99, 8'hAA, 8'hAA, 8'hBB, 8'hBB,
          8'hCC, 8'hCC, 8'hDD, 8'hDD};
    push_frame(f, 1);
    issue(8'h01, 8'h03, 8'h00, 16'h0008, 16'h0009);
    wait_idle("read_clamp");

    // Unsupported function with no exception is dropped silently.
    issue(8'h01, 8'h10, 8'h00, 16'h0000, 16'h0001);
    wait_idle("dropped");

    // Slow UART plus a request arriving mid-frame.
    busy_len = 50;
    f = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    push_frame(f, 0);
    issue(8'h01, 8'h06, 8'h00, 16'h0001, 16'h0003);
    repeat (30) @(negedge clk_in);
    dev_addr = 8'h05; func_code = 8'h03; exception = 8'h01;
    exception_done = 1'b1;
    @(negedge clk_in);
    exception_done = 1'b0;
    wait_idle("backpressure");
    busy_len = 2;

    // Reset in the middle of a read frame, then a clean frame.
    f = '{8'h01, 8'h04, 8'h06, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    push_frame(f, 1);
    issue(8'h01, 8'h04, 8'h00, 16'h0000, 16'h0003);
    n = 0;
    while (frame_bytes < 3 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (frame_bytes < 3) begin
      bad++;
      $display("FAIL reset_wait: got %0d bytes required 3", frame_bytes);
    end
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("reset_midframe");
    exp_q.delete();
    exp_frames = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    wait_idle("reset_recover");
    push_frame(f, 1);
    issue(8'h01, 8'h04, 8'h00, 16'h0000, 16'h0003);
    wait_idle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modbus_tx_frame.md
# modbus_tx_frame

Response transmitter for the Modbus RTU slave. On each `exception_done` pulse from the request checker, it builds one reply frame: an exception reply, a read-register reply (0x03/0x04) or a write-echo reply (0x06). It appends the CRC-16 and feeds the frame byte by byte to the UART transmitter, using a start/busy handshake.

## Interface
- `MAX_REGS`, 5: largest register quantity serialized in a read reply.
- `GAP_CYCLES`, 16'd1000: pre-frame silence in clk_in cycles; used only with `MODBUS_TX_GAP_EN`.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `dev_addr` input 8: slave address placed in byte 0.
- `exception_done` input 1: one-cycle request-complete pulse.
- `exception` input 8: 0x00 means normal reply, nonzero is the exception code; sampled with `exception_done`.
- `func_code` / `addr` / `data` inputs 8/16/16: request fields, sampled with `exception_done`.
- `reg_rd_addr` output 16: register-file read address.
- `reg_rd_data` input 16: read data, valid 1 cycle after `reg_rd_addr`.
- `tx_byte` output 8: byte to UART, valid while `tx_start` is high.
- `tx_start` output 1: one-cycle start pulse to UART.
- `tx_busy` input 1: UART busy; high no later than 1 cycle after `tx_start`.
- `busy` output 1: a frame is in progress.
- `tx_frame_done` output 1: one-cycle pulse after the last CRC byte is accepted and `tx_busy` has fallen.

## Operation
- Inputs are latched on `exception_done` while in IDLE. While `busy` is high, further `exception_done` pulses are ignored.
- Exception frame, 5 bytes: `dev_addr`, `func_code|0x80`, `exception`, CRC lo, CRC hi.
- Read frame (0x03/0x04, exception 0x00):
  - N = min(`data[7:0]`, `MAX_REGS`).
  - Bytes: `dev_addr`, `func_code`, 2N, then for each register k = 0..N-1: hi byte, lo byte of register `addr+k`, then CRC lo, CRC hi.
  - N = 0 gives a 5-byte frame with byte count 0x00.
- Write echo (0x06, exception 0x00), 8 bytes: `dev_addr`, 0x06, `addr` hi, `addr` lo, `data` hi, `data` lo, CRC lo, CRC hi. The register write itself is done elsewhere.
- Exception 0x00 with any other function code: the request is dropped, no bytes are sent, no `tx_frame_done` pulse, and the block returns to IDLE.
- CRC: init 0xFFFF, reflected poly 0xA001. It covers every byte before the CRC and is updated in the cycle each byte is sent.
- States:
  - IDLE → GAP (macro on) or LOAD.
  - LOAD: select byte; issue register read if needed → READ (1 cycle) → SEND.
  - SEND: wait for `tx_busy`=0, pulse `tx_start` → ACK (1 cycle guard) → WAITTX until `tx_busy`=0.
  - WAITTX → LOAD for the next byte, or → DONE after the CRC hi byte.
  - DONE: pulse `tx_frame_done` → IDLE.
- Byte index is a 4-bit counter; the largest frame is 5+2·`MAX_REGS` bytes, and the counter never wraps within a frame.
- Reset value of every output is 0. Asserting reset mid-frame aborts immediately and leaves no stale start pulse.

## Timing
- `exception_done` at cycle 0: inputs latched at the cycle-0 edge.
- First `tx_start` at cycle 2 if `tx_busy`=0 (macro off).
- Register bytes: `reg_rd_addr` is driven in LOAD. `reg_rd_data` is captured at the end of READ, and the hi byte is sent in the following SEND. The lo byte reuses the captured word with no second read.
- `tx_start` is never asserted while `tx_busy` is high, and never on two consecutive cycles.
- `busy` rises the cycle after `exception_done` and falls together with the `tx_frame_done` pulse.

## Configuration
- `MODBUS_TX_GAP_EN` defined: GAP state counts `GAP_CYCLES` idle cycles before byte 0. This enforces the RTU 3.5-character silence, and the first `tx_start` is delayed by `GAP_CYCLES`.
- Not defined: GAP state and counter are absent; IDLE goes directly to LOAD.

## Structure
- `modbus_pkg`:
  - function codes 0x03/0x04/0x06;
  - exception codes 0x01–0x03;
  - CRC init 0xFFFF and poly 0xA001;
  - exception flag 0x80;
  - the state encoding.
- Sub-module `modbus_crc16_byte`: registered single-cycle byte update with clear/enable/in_byte inputs and a crc output. The same sub-module can serve the receive-side CRC.

## Test plan
- Exception: `dev_addr`=0x01, func 0x03, exception 0x02 → bytes 01 83 02 C0 F1, then `tx_frame_done`.
- Write echo: func 0x06, addr 0x0001, data 0x0003, exception 0 → 01 06 00 01 00 03 98 0B.
- Read: func 0x04, addr 0, data 3, register file 0x1111/0x2222/0x3333 → 01 04 06 11 11 22 22 33 33 + CRC matching the software model; `reg_rd_addr` steps 0, 1, 2.
- UART backpressure: hold `tx_busy` high 50 cycles after each start → `tx_start` never while busy, byte order unchanged, `exception_done` mid-frame ignored.
- Dropped request: func 0x10, exception 0 → no `tx_start`, no `tx_frame_done`. Also data=9 on read → N clamped to 5, byte count 0x0A.
- Reset at byte 3 of a read frame → outputs 0 immediately; next request produces a complete, correct frame.
